avalon_msg_length_limiter: RTL and testbench

- Avalon-ST stage placed directly downstream of the SOP/EOP framing enforcer. It consumes that enforcer's well-framed message stream.
- Enforces a maximum message length in beats. An over-long message is cut at MAX_MSG_BEATS with EOP forced on its last kept beat, and its remaining beats are discarded up to the original EOP.
- Output is registered: one pipeline stage with standard ready backpressure.

---
 rtl/avalon_msg_length_limiter.sv | 164 ++++++++++++++++
 tb/tb_avalon_msg_length_limiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_msg_length_limiter.sv
// Avalon-ST message length limiter: cuts messages longer than MAX_MSG_BEATS,
// forces EOP on the last kept beat and discards the remainder up to the original EOP.
module avalon_msg_length_limiter #(
  parameter int unsigned DATA_WIDTH_IN_BYTES = 4,
  parameter int unsigned MAX_MSG_BEATS       = 16,
  localparam int unsigned DATA_W  = 8 * DATA_WIDTH_IN_BYTES,
  localparam int unsigned EMPTY_W = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1,
  localparam int unsigned CNT_W   = $clog2(MAX_MSG_BEATS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  // framed input stream
  input  logic [DATA_W-1:0]  framed_msg_data_i,
  input  logic [EMPTY_W-1:0] framed_msg_empty_i,
  input  logic               framed_msg_sop_i,
  input  logic               framed_msg_eop_i,
  input  logic               framed_msg_valid_i,
  output logic               framed_msg_rdy_o,
  // length-limited output stream
  output logic [DATA_W-1:0]  limited_msg_data_o,
  output logic [EMPTY_W-1:0] limited_msg_empty_o,
  output logic               limited_msg_sop_o,
  output logic               limited_msg_eop_o,
  output logic               limited_msg_valid_o,
  input  logic               limited_msg_rdy_i,
  // event pulses
  output logic               truncated_indi_o,
  output logic               dropped_beat_indi_o
);

  typedef enum logic [1:0] {
    BETWEEN_MSG = 2'd0,
    IN_MSG      = 2'd1,
    DISCARD     = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [EMPTY_W-1:0] empty_q, empty_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic               valid_q, valid_d;
  logic               trunc_q, trunc_d;
  logic               drop_q, drop_d;

  logic               rdy_c;
  logic               acc_c;
  logic               load_c;
  logic               force_eop_c;

  // Discard never stalls upstream; otherwise the single output slot must be free or draining.
  assign rdy_c = (state_q == DISCARD) | ~valid_q | limited_msg_rdy_i;
  assign acc_c = framed_msg_valid_i & rdy_c;

  assign framed_msg_rdy_o    = rdy_c;
  assign limited_msg_data_o  = data_q;
  assign limited_msg_empty_o = empty_q;
  assign limited_msg_sop_o   = sop_q;
  assign limited_msg_eop_o   = eop_q;
  assign limited_msg_valid_o = valid_q;
  assign truncated_indi_o    = trunc_q;
  assign dropped_beat_indi_o = drop_q;

  // State, counter, output slot and indicator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= BETWEEN_MSG;
      cnt_q   <= '0;
      data_q  <= '0;
      empty_q <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= 1'b0;
      trunc_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      empty_q <= empty_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      valid_q <= valid_d;
      trunc_q <= trunc_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state and output-slot logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    empty_d     = empty_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    valid_d     = valid_q & ~limited_msg_rdy_i;
    trunc_d     = 1'b0;
    drop_d      = 1'b0;
    load_c      = 1'b0;
    force_eop_c = 1'b0;

    unique case (state_q)
      BETWEEN_MSG: begin
        if (acc_c) begin
          if (!framed_msg_sop_i) begin
            drop_d = 1'b1;
          end else if (framed_msg_eop_i) begin
            load_c = 1'b1;
            cnt_d  = '0;
          end else if (MAX_MSG_BEATS == 1) begin
            load_c      = 1'b1;
            force_eop_c = 1'b1;
            trunc_d     = 1'b1;
            state_d     = DISCARD;
          end else begin
            load_c  = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = IN_MSG;
          end
        end
      end
      IN_MSG: begin
        if (acc_c) begin
          load_c = 1'b1;
          if (framed_msg_eop_i) begin
            cnt_d   = '0;
            state_d = BETWEEN_MSG;
          end else if (cnt_q == CNT_W'(MAX_MSG_BEATS - 1)) begin
            force_eop_c = 1'b1;
            trunc_d     = 1'b1;
            state_d     = DISCARD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DISCARD: begin
        if (acc_c) begin
          drop_d = 1'b1;
          if (framed_msg_eop_i) begin
            cnt_d   = '0;
            state_d = BETWEEN_MSG;
          end
        end
      end
      default: begin
        state_d = BETWEEN_MSG;
        cnt_d   = '0;
      end
    endcase

    // A stray sop inside a message is forwarded as plain data.
    if (load_c) begin
      valid_d = 1'b1;
      data_d  = framed_msg_data_i;
      sop_d   = framed_msg_sop_i & (state_q == BETWEEN_MSG);
      eop_d   = framed_msg_eop_i | force_eop_c;
      empty_d = (framed_msg_eop_i && !force_eop_c) ? framed_msg_empty_i : '0;
    end
  end

endmodule

// File: tb/tb_avalon_msg_length_limiter.sv
// Directed bench for avalon_msg_length_limiter: three instances (MAX 4, 1, 16) checked
// every cycle against a message-position model plus literal per-test totals.
module tb_avalon_msg_length_limiter;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  e;
    logic        s;
    logic        p;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;

  logic [31:0] din   [3];
  logic [1:0]  ein   [3];
  logic        sin   [3];
  logic        pin   [3];
  logic        vin   [3];
  logic        rin   [3];
  logic [31:0] dout  [3];
  logic [1:0]  eout  [3];
  logic        sout  [3];
  logic        pout  [3];
  logic        vout  [3];
  logic        ordy  [3];
  logic        tr    [3];
  logic        dr    [3];

  bit          tog    [3];
  bit          in_msg [3];
  int          pos    [3];
  bit          q_full [3];
  beat_t       q_b    [3];
  bit          exp_tr [3];
  bit          exp_dr [3];

  int n_vec = 0, n_miss = 0;
  int cnt_out, cnt_tr, cnt_dr, last_empty, n_eop;

  always #5 clk = ~clk;

  avalon_msg_length_limiter #(.DATA_WIDTH_IN_BYTES(4), .MAX_MSG_BEATS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .framed_msg_data_i(din[0]), .framed_msg_empty_i(ein[0]), .framed_msg_sop_i(sin[0]),
    .framed_msg_eop_i(pin[0]), .framed_msg_valid_i(vin[0]), .framed_msg_rdy_o(rin[0]),
    .limited_msg_data_o(dout[0]), .limited_msg_empty_o(eout[0]), .limited_msg_sop_o(sout[0]),
    .limited_msg_eop_o(pout[0]), .limited_msg_valid_o(vout[0]), .limited_msg_rdy_i(ordy[0]),
    .truncated_indi_o(tr[0]), .dropped_beat_indi_o(dr[0]));

  avalon_msg_length_limiter #(.DATA_WIDTH_IN_BYTES(4), .MAX_MSG_BEATS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .framed_msg_data_i(din[1]), .framed_msg_empty_i(ein[1]), .framed_msg_sop_i(sin[1]),
    .framed_msg_eop_i(pin[1]), .framed_msg_valid_i(vin[1]), .framed_msg_rdy_o(rin[1]),
    .limited_msg_data_o(dout[1]), .limited_msg_empty_o(eout[1]), .limited_msg_sop_o(sout[1]),
    .limited_msg_eop_o(pout[1]), .limited_msg_valid_o(vout[1]), .limited_msg_rdy_i(ordy[1]),
    .truncated_indi_o(tr[1]), .dropped_beat_indi_o(dr[1]));

  avalon_msg_length_limiter #(.DATA_WIDTH_IN_BYTES(4), .MAX_MSG_BEATS(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .framed_msg_data_i(din[2]), .framed_msg_empty_i(ein[2]), .framed_msg_sop_i(sin[2]),
    .framed_msg_eop_i(pin[2]), .framed_msg_valid_i(vin[2]), .framed_msg_rdy_o(rin[2]),
    .limited_msg_data_o(dout[2]), .limited_msg_empty_o(eout[2]), .limited_msg_sop_o(sout[2]),
    .limited_msg_eop_o(pout[2]), .limited_msg_valid_o(vout[2]), .limited_msg_rdy_i(ordy[2]),
    .truncated_indi_o(tr[2]), .dropped_beat_indi_o(dr[2]));

  function automatic int max_of(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      default: return 16;
    endcase
  endfunction

  // Once the kept part of a message is full, every further beat up to eop is discarded.
  function automatic bit discarding(input int k);
    return in_msg[k] && (pos[k] + 1 >= max_of(k));
  endfunction

  task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic reset_models();
    for (int k = 0; k < 3; k++) begin
      in_msg[k] = 1'b0;
      pos[k]    = 0;
      q_full[k] = 1'b0;
      exp_tr[k] = 1'b0;
      exp_dr[k] = 1'b0;
    end
  endtask

  task automatic clear_stats();
    cnt_out = 0; cnt_tr = 0; cnt_dr = 0; last_empty = -1; n_eop = 0;
  endtask

  // One clock of instance k: evaluate the accept/take that the next edge will see,
  // advance the model, then check all outputs just after the edge.
  task automatic cycle(input int k, output bit acc);
    bit take;
    bit fe;
    bit fwd_ok;
    int mx;
    mx = max_of(k);
    if (tog[k]) ordy[k] = ~ordy[k];
    #1;
    chk(k, "in_rdy", 32'(rin[k]), 32'(discarding(k) || !q_full[k] || ordy[k]));
    acc  = vin[k] && rin[k];
    take = vout[k] && ordy[k];
    if (take) begin
      q_full[k] = 1'b0;
      cnt_out++;
      if (pout[k]) begin
        n_eop++;
        last_empty = int'(eout[k]);
      end
    end
    exp_tr[k] = 1'b0;
    exp_dr[k] = 1'b0;
    if (acc) begin
      fwd_ok = 1'b1;
      fe     = 1'b0;
      if (!in_msg[k]) begin
        if (!sin[k]) begin
          exp_dr[k] = 1'b1;
          fwd_ok    = 1'b0;
        end else begin
          in_msg[k] = 1'b1;
          pos[k]    = 0;
        end
      end else begin
        pos[k]++;
      end
      if (fwd_ok) begin
        if (pos[k] < mx) begin
          fe          = (pos[k] == mx - 1) && !pin[k];
          q_b[k].d    = din[k];
          q_b[k].s    = (pos[k] == 0);
          q_b[k].p    = pin[k] || fe;
          q_b[k].e    = (pin[k] && !fe) ? ein[k] : 2'd0;
          q_full[k]   = 1'b1;
          exp_tr[k]   = fe;
        end else begin
          exp_dr[k] = 1'b1;
        end
        if (pin[k]) in_msg[k] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk(k, "out_valid", 32'(vout[k]), 32'(q_full[k]));
    if (q_full[k]) begin
      chk(k, "out_data",  dout[k],        q_b[k].d);
      chk(k, "out_sop",   32'(sout[k]),   32'(q_b[k].s));
      chk(k, "out_eop",   32'(pout[k]),   32'(q_b[k].p));
      chk(k, "out_empty", 32'(eout[k]),   32'(q_b[k].e));
    end
    chk(k, "trunc_pulse", 32'(tr[k]), 32'(exp_tr[k]));
    chk(k, "drop_pulse",  32'(dr[k]), 32'(exp_dr[k]));
    if (tr[k]) cnt_tr++;
    if (dr[k]) cnt_dr++;
  endtask

  task automatic put_beat(input int k, input logic [31:0] d, input bit s, input bit p,
                          input logic [1:0] e);
    bit acc;
    bit done;
    din[k] = d; sin[k] = s; pin[k] = p; ein[k] = e; vin[k] = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      cycle(k, acc);
      done = acc;
    end
    if (!done) chk(k, "accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic send(input int k, input int n, input logic [1:0] emp, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      put_beat(k, base + 32'(i), i == 0, i == n - 1, (i == n - 1) ? emp : 2'(i));
    vin[k] = 1'b0;
  endtask

  task automatic idle(input int k, input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(k, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[k] = '0; ein[k] = '0; sin[k] = 1'b0; pin[k] = 1'b0; vin[k] = 1'b0;
      ordy[k] = 1'b1; tog[k] = 1'b0;
    end
    reset_models();
    clear_stats();
    #2;
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_valid", 32'(vout[k]), 32'(0));
      chk(k, "rst_eop",   32'(pout[k]), 32'(0));
      chk(k, "rst_trunc", 32'(tr[k]),   32'(0));
      chk(k, "rst_drop",  32'(dr[k]),   32'(0));
    end
    #10 rst = 1'b1;
    @(posedge clk);
    #1;

    // MAX=4, 3-beat message passes through intact
    clear_stats();
    send(0, 3, 2'd2, 32'h100);
    idle(0, 3);
    chk(0, "t1_beats", 32'(cnt_out), 32'(3));
    chk(0, "t1_trunc", 32'(cnt_tr), 32'(0));
    chk(0, "t1_drop", 32'(cnt_dr), 32'(0));
    chk(0, "t1_last_empty", 32'(last_empty), 32'(2));

    // MAX=4, exactly 4 beats: no truncation
    clear_stats();
    send(0, 4, 2'd3, 32'h200);
    idle(0, 3);
    chk(0, "t2_beats", 32'(cnt_out), 32'(4));
    chk(0, "t2_eops", 32'(n_eop), 32'(1));
    chk(0, "t2_trunc", 32'(cnt_tr), 32'(0));
    chk(0, "t2_last_empty", 32'(last_empty), 32'(3));

    // MAX=4, 7 beats cut to 4, then a single-beat message
    clear_stats();
    send(0, 7, 2'd1, 32'h300);
    send(0, 1, 2'd3, 32'h400);
    idle(0, 3);
    chk(0, "t3_beats", 32'(cnt_out), 32'(5));
    chk(0, "t3_trunc", 32'(cnt_tr), 32'(1));
    chk(0, "t3_drop", 32'(cnt_dr), 32'(3));
    chk(0, "t3_eops", 32'(n_eop), 32'(2));
    chk(0, "t3_last_empty", 32'(last_empty), 32'(3));

    // MAX=1, 3-beat message cut to 1, then single-beat passes
    clear_stats();
    send(1, 3, 2'd2, 32'h500);
    idle(1, 3);
    chk(1, "t4_beats", 32'(cnt_out), 32'(1));
    chk(1, "t4_trunc", 32'(cnt_tr), 32'(1));
    chk(1, "t4_drop", 32'(cnt_dr), 32'(2));
    chk(1, "t4_cut_empty", 32'(last_empty), 32'(0));
    send(1, 1, 2'd1, 32'h600);
    idle(1, 3);
    chk(1, "t4_beats2", 32'(cnt_out), 32'(2));
    chk(1, "t4_trunc2", 32'(cnt_tr), 32'(1));
    chk(1, "t4_last_empty2", 32'(last_empty), 32'(1));

    // MAX=16, downstream ready toggling every cycle
    clear_stats();
    tog[2] = 1'b1;
    send(2, 5, 2'd2, 32'h700);
    idle(2, 6);
    tog[2] = 1'b0;
    ordy[2] = 1'b1;
    idle(2, 2);
    chk(2, "t5_beats", 32'(cnt_out), 32'(5));
    chk(2, "t5_eops", 32'(n_eop), 32'(1));
    chk(2, "t5_trunc", 32'(cnt_tr), 32'(0));
    chk(2, "t5_drop", 32'(cnt_dr), 32'(0));

    // MAX=4, reset during beat 2 of a 6-beat message
    clear_stats();
    put_beat(0, 32'h800, 1'b1, 1'b0, 2'd0);
    put_beat(0, 32'h801, 1'b0, 1'b0, 2'd1);
    din[0] = 32'h802; sin[0] = 1'b0; pin[0] = 1'b0; vin[0] = 1'b1;
    rst = 1'b0;
    #1;
    chk(0, "t6_rst_valid", 32'(vout[0]), 32'(0));
    chk(0, "t6_rst_sop",   32'(sout[0]), 32'(0));
    chk(0, "t6_rst_eop",   32'(pout[0]), 32'(0));
    chk(0, "t6_rst_data",  dout[0],      32'(0));
    chk(0, "t6_rst_empty", 32'(eout[0]), 32'(0));
    chk(0, "t6_rst_trunc", 32'(tr[0]),   32'(0));
    chk(0, "t6_rst_drop",  32'(dr[0]),   32'(0));
    vin[0] = 1'b0;
    reset_models();
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    put_beat(0, 32'h803, 1'b0, 1'b0, 2'd0);
    vin[0] = 1'b0;
    idle(0, 1);
    chk(0, "t6_orphan_drop", 32'(cnt_dr), 32'(1));
    chk(0, "t6_orphan_beats", 32'(cnt_out), 32'(0));
    send(0, 2, 2'd2, 32'h900);
    idle(0, 3);
    chk(0, "t6_clean_beats", 32'(cnt_out), 32'(2));
    chk(0, "t6_clean_empty", 32'(last_empty), 32'(2));
    chk(0, "t6_clean_trunc", 32'(cnt_tr), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
